// File: rtl/nds_line_scaler.sv
// Scales a line-synced source stream into a fixed-timing panel frame via two ping-pong line banks.
// Optional frame locking to in_vsync is enabled by defining NDS_SCALER_FRAME_LOCK_EN.
module nds_line_scaler #(
  parameter int PIX_W       = 18,
  parameter int IN_W        = 256,
  parameter int IN_H        = 192,
  parameter int SCALE_LOG2  = 1,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT       = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 1,
  parameter int V_ACT_START = 7,
  parameter int V_ACT       = 480,
  parameter int WIN_X0      = 64,
  parameter int WIN_Y0      = 48,
  parameter logic [PIX_W-1:0] BORDER_COLOR = 18'h20820
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_hsync,
  input  logic             in_vsync,
  input  logic [PIX_W-1:0] in_data,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             de,
  output logic [PIX_W-1:0] out_data,
  output logic             short_line
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int AW = $clog2(IN_W);
  localparam int PW = $clog2(IN_W + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_SYNC);
  localparam logic [HW-1:0] H_DE_LO  = HW'(H_ACT_START);
  localparam logic [HW-1:0] H_DE_HI  = HW'(H_ACT_START + H_ACT);
  localparam logic [HW-1:0] H_WIN_LO = HW'(H_ACT_START + WIN_X0);
  localparam logic [HW-1:0] H_WIN_HI = HW'(H_ACT_START + WIN_X0 + (IN_W << SCALE_LOG2));
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_SYNC);
  localparam logic [VW-1:0] V_DE_LO  = VW'(V_ACT_START);
  localparam logic [VW-1:0] V_DE_HI  = VW'(V_ACT_START + V_ACT);
  localparam logic [VW-1:0] V_WIN_LO = VW'(V_ACT_START + WIN_Y0);
  localparam logic [VW-1:0] V_WIN_HI = VW'(V_ACT_START + WIN_Y0 + (IN_H << SCALE_LOG2));
  localparam logic [VW-1:0] AY_MASK  = VW'((1 << SCALE_LOG2) - 1);
  localparam logic [PW-1:0] PTR_MAX  = PW'(IN_W);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          hs_prev_q;
  logic          wr_bank_q, wr_bank_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          wr_any_q, wr_any_d;
  logic          short_d;
  logic          rd_bank_q, rd_bank_d;
  logic          hs1_q, vs1_q, de1_q, win1_q;
  logic [PIX_W-1:0] rd_data_q;
  logic [PIX_W-1:0] line_mem [0:2*IN_W-1];

  logic          hs_fall, vs_fall;
  logic          wr_en;
  logic [AW:0]   wr_addr, rd_addr;
  logic          in_h_win, in_v_win, latch_rd;
  logic [HW-1:0] ax;
  logic [VW-1:0] ay;

  assign hs_fall = hs_prev_q & ~in_hsync;

`ifdef NDS_SCALER_FRAME_LOCK_EN
  logic vs_prev_q;
  assign vs_fall = vs_prev_q & ~in_vsync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vs_prev_q <= 1'b1;
    else        vs_prev_q <= in_vsync;
  end
`else
  logic unused_vsync;
  assign unused_vsync = in_vsync;
  assign vs_fall = 1'b0;
`endif

  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end
    if (vs_fall) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end
  end

  // A pixel arriving with the hsync edge belongs to the new line, at index 0.
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_ptr_d  = wr_ptr_q;
    wr_any_d  = wr_any_q;
    short_d   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = {wr_bank_q, wr_ptr_q[AW-1:0]};
    if (hs_fall) begin
      short_d   = wr_any_q && (wr_ptr_q < PTR_MAX);
      wr_bank_d = ~wr_bank_q;
      wr_ptr_d  = in_valid ? PW'(1) : '0;
      wr_any_d  = in_valid;
      wr_en     = in_valid;
      wr_addr   = {~wr_bank_q, {AW{1'b0}}};
    end else if (in_valid) begin
      wr_any_d = 1'b1;
      if (wr_ptr_q < PTR_MAX) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
    end
    if (vs_fall) begin
      wr_bank_d = 1'b0;
      wr_ptr_d  = '0;
      wr_any_d  = 1'b0;
      wr_en     = 1'b0;
    end
  end

  // Window bounds are compared before subtracting so wrapped offsets never alias inside.
  always_comb begin
    in_h_win  = (h_cnt_q >= H_WIN_LO) && (h_cnt_q < H_WIN_HI);
    in_v_win  = (v_cnt_q >= V_WIN_LO) && (v_cnt_q < V_WIN_HI);
    ax        = h_cnt_q - H_WIN_LO;
    ay        = v_cnt_q - V_WIN_LO;
    latch_rd  = in_v_win && (h_cnt_q == H_WIN_LO) && ((ay & AY_MASK) == '0);
    rd_bank_d = latch_rd ? ~wr_bank_q : rd_bank_q;
    rd_addr   = {rd_bank_d, AW'(ax >> SCALE_LOG2)};
  end

  always_ff @(posedge clk) begin
    if (wr_en) line_mem[wr_addr] <= in_data;
    rd_data_q <= line_mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      hs_prev_q  <= 1'b1;
      wr_bank_q  <= 1'b0;
      wr_ptr_q   <= '0;
      wr_any_q   <= 1'b0;
      rd_bank_q  <= 1'b1;
      short_line <= 1'b0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      de1_q      <= 1'b0;
      win1_q     <= 1'b0;
      hsync_out  <= 1'b1;
      vsync_out  <= 1'b1;
      de         <= 1'b0;
      out_data   <= '0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      hs_prev_q  <= in_hsync;
      wr_bank_q  <= wr_bank_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_any_q   <= wr_any_d;
      rd_bank_q  <= rd_bank_d;
      short_line <= short_d;
      hs1_q      <= ~(h_cnt_q < H_SYNC_E);
      vs1_q      <= ~(v_cnt_q < V_SYNC_E);
      de1_q      <= (h_cnt_q >= H_DE_LO) && (h_cnt_q < H_DE_HI) &&
                    (v_cnt_q >= V_DE_LO) && (v_cnt_q < V_DE_HI);
      win1_q     <= in_h_win && in_v_win;
      hsync_out  <= hs1_q;
      vsync_out  <= vs1_q;
      de         <= de1_q;
      out_data   <= !de1_q ? '0 : (win1_q ? rd_data_q : BORDER_COLOR);
    end
  end

endmodule

// File: doc/nds_line_scaler.md
NDS_LINE_SCALER -- requirements
Module: nds_line_scaler

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- PIX_W, 18, pixel width, R[5:0] G[11:6] B[17:12].
- IN_W, 256, source pixels per line.
- IN_H, 192, source lines per frame.
- SCALE_LOG2, 1, replication factor 2^SCALE_LOG2, range 0..2.
- H_TOTAL 800, H_SYNC 96, H_ACT_START 144, H_ACT 640: output horizontal timing, in clk cycles.
- V_TOTAL 525, V_SYNC 1, V_ACT_START 7, V_ACT 480: output vertical timing, in lines.
- WIN_X0 64, WIN_Y0 48: scaled-window offset inside the active area.
- BORDER_COLOR, 18'h20820, colour outside the window.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, input, 1: single clock; output pixel rate.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: source pixel strobe, already synchronised to clk.
- in_hsync, input, 1: source line sync, active low, synchronised.
- in_vsync, input, 1: source frame sync, active low, synchronised.
- in_data, input, PIX_W: source pixel.
- hsync_out, output, 1: panel hsync, active low.
- vsync_out, output, 1: panel vsync, active low.
- de, output, 1: panel data enable.
- out_data, output, PIX_W: panel pixel.
- short_line, output, 1: one-cycle pulse when a completed source line had fewer than IN_W pixels.
REQ-003 Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.

Function
REQ-004 Input side: a falling edge of in_hsync (current low, previous sample high) resets the write pointer to 0, toggles the write bank, and marks the previous bank complete.
REQ-005 Each in_valid cycle writes in_data to the current bank at the write pointer, then increments it. Writes at pointer >= IN_W are discarded and the pointer saturates at IN_W.
REQ-006 On a falling edge of in_hsync, if the pointer is < IN_W and at least one pixel was written since the last edge, short_line pulses high for exactly one cycle.
REQ-007 Line buffers: two banks of IN_W x PIX_W. The read bank never equals the current write bank.
REQ-008 Output timing: h_cnt runs 0..H_TOTAL-1 and wraps. v_cnt increments on each h_cnt wrap and wraps after V_TOTAL-1.
- hsync_out is low while h_cnt < H_SYNC.
- vsync_out is low while v_cnt < V_SYNC.
- de is high when h_cnt is in [H_ACT_START, H_ACT_START+H_ACT) and v_cnt is in [V_ACT_START, V_ACT_START+V_ACT).
REQ-009 Window: active-relative position ax = h_cnt-H_ACT_START-WIN_X0, ay = v_cnt-V_ACT_START-WIN_Y0. The window is 0 <= ax < IN_W<<SCALE_LOG2 and 0 <= ay < IN_H<<SCALE_LOG2.
REQ-010 Inside the window, out_data = bank[ax>>SCALE_LOG2]. Each source pixel repeats 2^SCALE_LOG2 times horizontally.
REQ-011 The read bank is latched at the first window cycle of each output line where ay[SCALE_LOG2-1:0]==0. Each source line therefore repeats for 2^SCALE_LOG2 output lines. With SCALE_LOG2=0, the bank is latched every window line.
REQ-012 Outside the window with de high, out_data = BORDER_COLOR. With de low, out_data = 0.
REQ-013 hsync_out, vsync_out, de and out_data are registered and mutually aligned. Latency from counter value to pins is a fixed 2 clk cycles.
REQ-014 Counter arithmetic is unsigned. Negative ax/ay (wrapped values) are treated as outside the window, using compares made before subtraction.
REQ-015 Simultaneous in_valid and in_hsync falling edge: the pointer reset and bank toggle take priority, and the pixel is written to index 0 of the new bank.

Reset
REQ-016 While rst_n is low:
- hsync_out=1, vsync_out=1, de=0, out_data=0, short_line=0.
- h_cnt=0, v_cnt=0, write pointer=0, write bank=0, read bank=1.
REQ-017 Reset asserted mid-line aborts the line immediately. After release, output resumes at h_cnt=0, v_cnt=0 on the first clk edge. Buffer contents are not cleared.

Configuration
REQ-018 Macro NDS_SCALER_FRAME_LOCK_EN controls frame locking.
- Defined: a falling edge of in_vsync forces v_cnt=0 and h_cnt=0 on the next cycle, and the write bank and pointer reset to 0.
- Undefined: in_vsync is ignored and output timing free-runs.

Verification
REQ-019 Reset release with no input -> hsync_out low for 96 cycles every 800. vsync_out low for 1 line every 525. de high 640 cycles per line on lines 7..486.
REQ-020 SCALE_LOG2=1, line of 256 pixels with value=index -> each value appears on 2 consecutive de cycles starting at h_cnt=208, on 2 consecutive lines. BORDER_COLOR at h_cnt=207 and 720.
REQ-021 Source line of 200 pixels followed by an in_hsync falling edge -> short_line high exactly 1 cycle. Pixels 200..255 show stale data from the earlier contents of that bank.
REQ-022 300 in_valid strobes in one line -> only 256 written, no short_line, and bank 0 index 0 is not overwritten.
REQ-023 FRAME_LOCK_EN defined, in_vsync falls at v_cnt=300 -> vsync_out low 2 cycles later at h_cnt=0. Undefined -> no disturbance to the counters.
REQ-024 rst_n pulsed low at h_cnt=400 -> all outputs at reset values within the same cycle. Next hsync_out low begins 2 cycles after release.
